sym_feeder: RTL
===============

Name: sym_feeder

Overview:
- Upstream stage for the 6-bit symbol-processing core, which consumes x_in/stbi.
- Buffers producer symbols in a small FIFO and presents them one at a time on x_in.
- Each symbol gets a single-cycle stbi-low strike, then a fixed stbi-high guard window so the core finishes processing before the next symbol.
- Also provides a sent-symbol counter and a sticky overflow flag.

Parameters:
- DEPTH, 8, FIFO entries; power of two, range 2..64.
- HOLD_CYCLES, 12, stbi-high guard cycles after each strike; must be at least 1. Also used as the post-reset boot wait.
- CNT_W, 8, width of sent_cnt.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- push_valid  in  1  producer offers push_data this cycle
- push_data  in  6  symbol to enqueue
- push_ready  out  1  FIFO not full; a push is accepted only when push_valid && push_ready
- x_in  out  6  symbol presented to the core
- stbi  out  1  low exactly during strike cycles, high otherwise
- busy  out  1  high when state != IDLE or FIFO not empty
- sent_cnt  out  CNT_W  number of strikes issued, wraps modulo 2^CNT_W
- overflow  out  1  sticky; set when push_valid && !push_ready; cleared only by reset

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clock. All state is on the rising edge.
- Reset values:
  - state = BOOT, boot/hold counter = HOLD_CYCLES-1
  - x_in = 0, stbi = 1
  - FIFO empty, sent_cnt = 0, overflow = 0
  - Reset mid-operation discards queued symbols and aborts any strike or hold.
- FSM states: BOOT, IDLE, LOAD, HOLD. stbi = 0 iff state == LOAD; it is decoded from the registered state, so there are no glitches.
- BOOT: stbi = 1. Counter decrements each cycle; at 0, go to IDLE. This gives HOLD_CYCLES cycles of stbi high after reset so the core settles in its input-waiting state.
- IDLE: if the FIFO is non-empty, on the same edge register x_in <= FIFO head and go to LOAD. Otherwise stay in IDLE; x_in keeps its last value.
- LOAD (exactly 1 cycle): on exit, pop the FIFO head, increment sent_cnt, load counter = HOLD_CYCLES-1, go to HOLD.
- HOLD: stbi = 1, x_in held. Counter decrements; at 0, go to IDLE.
- Latency:
  - A push accepted at edge t into an empty FIFO with state IDLE gives x_in valid and stbi = 0 during the cycle after edge t+1, i.e. the second cycle after the push.
  - Back-to-back strikes are spaced HOLD_CYCLES+2 cycles apart (LOAD, HOLD × HOLD_CYCLES, IDLE).
- FIFO:
  - Circular buffer with read/write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
  - push_ready = (count != DEPTH), combinational from registered count.
  - Simultaneous push and pop: both take effect and count is unchanged.
  - A push while full is rejected even if a pop occurs the same cycle; overflow is set.
  - Pointers wrap from DEPTH-1 to 0.
- x_in is a plain 6-bit copy, with no transformation. Codes 0 and 63 pass like any other value.
- sent_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Package sym_feeder_pkg:
  - SYM_W = 6
  - state enum {BOOT, IDLE, LOAD, HOLD}, 2 bits, encodings 0..3
- Sub-module sym_fifo (DEPTH, SYM_W):
  - Inputs: push, push_data, pop.
  - Outputs: head, empty, full, count.
  - Instantiated once; the FSM and counters live in the top module.

Test Plan:
1. Reset release, no pushes → stbi = 1 for all cycles, state reaches IDLE after 12 cycles, x_in = 0, sent_cnt = 0, busy = 0 after boot.
2. After boot, single push of 6'd13 → two cycles later x_in = 13 with stbi = 0 for exactly 1 cycle, then stbi = 1 for 12 cycles; sent_cnt = 1.
3. Push 0, 63, 26 on three consecutive cycles → three strikes with x_in = 0, 63, 26 in order, stbi-low cycles 14 cycles apart; sent_cnt = 3.
4. Hold push_valid for 10 cycles during BOOT with DEPTH = 8 → first 8 accepted; push_ready = 0 afterwards; overflow = 1 and stays 1; exactly 8 strikes follow boot.
5. Assert reset during HOLD with 3 symbols queued → next cycle stbi = 1, FIFO empty, sent_cnt = 0, overflow = 0; no strike occurs within 12 cycles of release.
6. Full FIFO in LOAD with simultaneous push → push rejected, overflow = 1, count becomes DEPTH-1; next cycle push_ready = 1 and a push of 6'd5 is accepted and later struck last.

Source files
------------

// File: rtl/sym_feeder_pkg.sv
// Shared types and constants for the symbol feeder slice.
// No logic; state encoding and symbol width live here so the core-facing width has one definition.
// Backpressure is not applicable to a package.
package sym_feeder_pkg;

  localparam int SYM_W = 6;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    IDLE = 2'd1,
    LOAD = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Bits needed to hold a down-counter starting at hold-1 (never narrower than one bit).
  function automatic int cnt_w(input int hold);
    return ($clog2(hold) < 1) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Circular-buffer symbol FIFO with registered count.
// Latency: a pushed word is visible on head the cycle after the push edge (when the FIFO was empty).
// Backpressure: push ignored while full (even with a concurrent pop); pop ignored while empty.
module sym_fifo #(
  parameter int DEPTH = 8,
  parameter int SYM_W = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [SYM_W-1:0]         push_data,
  input  logic                     pop,
  output logic [SYM_W-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [SYM_W-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Fullness is judged on the registered count, so a same-cycle pop never frees room for a push.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; count moves only on unmatched push/pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers are cleared.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sym_feeder.sv
// Feeds buffered symbols to the core: one stbi-low strike per symbol, then a stbi-high guard window.
// Latency: push into idle empty feeder -> strike in the second cycle after the push; strikes HOLD_CYCLES+2 apart.
// Backpressure: push_ready drops when the FIFO is full; a rejected push sets the sticky overflow flag.
module sym_feeder
  import sym_feeder_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 12,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [SYM_W-1:0] push_data,
  output logic             push_ready,
  output logic [SYM_W-1:0] x_in,
  output logic             stbi,
  output logic             busy,
  output logic [CNT_W-1:0] sent_cnt,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

  state_t           state;
  state_t           state_nxt;
  logic [HW-1:0]    hold_cnt;
  logic [SYM_W-1:0] fifo_head;
  logic             fifo_empty;
  logic             fifo_full;
  logic [AW:0]      fifo_count;
  logic             fifo_push;
  logic             fifo_pop;

  sym_fifo #(
    .DEPTH (DEPTH),
    .SYM_W (SYM_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // State register; reset always restarts the boot settle window.
  always_ff @(posedge clock) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  // Next state: boot and hold both run the shared down-counter to zero before returning to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    if (hold_cnt == '0) state_nxt = IDLE;
      IDLE:    if (!fifo_empty)    state_nxt = LOAD;
      LOAD:                        state_nxt = HOLD;
      HOLD:    if (hold_cnt == '0) state_nxt = IDLE;
      default:                     state_nxt = BOOT;
    endcase
  end

  // Outputs decoded from registered state only, so stbi cannot glitch.
  always_comb begin
    stbi       = (state != LOAD);
    busy       = (state != IDLE) || !fifo_empty;
    push_ready = (fifo_count != FULL_CNT);
    fifo_push  = push_valid && !fifo_full;
    fifo_pop   = (state == LOAD);
  end

  // Datapath: guard counter, presented symbol, strike counter and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt <= HOLD_INIT;
      x_in     <= '0;
      sent_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_valid && fifo_full) overflow <= 1'b1;
      case (state)
        BOOT, HOLD: if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
        IDLE:       if (!fifo_empty)    x_in     <= fifo_head;
        LOAD: begin
          hold_cnt <= HOLD_INIT;
          sent_cnt <= sent_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
